// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester MemPort arbiter.
package mem_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;
    localparam int OWNER_W = $clog2(NUM_REQ);

    typedef logic [OWNER_W-1:0] owner_t;

    typedef enum logic {
        ARB,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/mem_port_if.sv
// MemPort: valid/ready request channel plus an in-order rvalid/rdata response channel.
interface MemPort;
    import mem_arb_pkg::*;

    logic                  valid;
    logic                  ready;
    logic                  write_en;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   byte_en;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;

    modport Master (
        output valid, write_en, addr, wdata, byte_en,
        input  ready, rdata, rvalid
    );

    modport Slave (
        input  valid, write_en, addr, wdata, byte_en,
        output ready, rdata, rvalid
    );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// Synchronous FIFO of owner IDs, one entry per read accepted downstream and not yet answered.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = OWNER_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = slots[rd_ptr];

    // NOTE: storage is not reset; only pointers and count define which slots are valid.
    always_ff @(posedge clk) begin
        if (push_ok) slots[wr_ptr] <= din;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream MemPort between two requesters,
// holding the grant while stalled and routing in-order read responses to their owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic   clk,
    input  logic   rst,
    MemPort.Slave  up0,
    MemPort.Slave  up1,
    MemPort.Master mem,
    output logic   rsp_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t       state;
    owner_t           rr_last;
    owner_t           held;
    owner_t           sel;
    owner_t           head;
    logic             sel_valid;
    logic             sel_we;
    logic             allow;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel = owner_t'(0);
        if (state == HOLD)               sel = held;
        else if (up0.valid && up1.valid) sel = ~rr_last;
        else if (up1.valid)              sel = owner_t'(1);
    end

    assign sel_valid    = (sel == owner_t'(1)) ? up1.valid    : up0.valid;
    assign sel_we       = (sel == owner_t'(1)) ? up1.write_en : up0.write_en;
    assign mem.write_en = sel_we;
    assign mem.addr     = (sel == owner_t'(1)) ? up1.addr     : up0.addr;
    assign mem.wdata    = (sel == owner_t'(1)) ? up1.wdata    : up0.wdata;
    assign mem.byte_en  = (sel == owner_t'(1)) ? up1.byte_en  : up0.byte_en;

    // Reads stall on the registered full flag even when a pop frees a slot this cycle.
    assign allow     = sel_we | ~fifo_full;
    assign mem.valid = sel_valid & allow & ~rst;
    assign accept    = mem.valid & mem.ready;
    assign up0.ready = mem.ready & allow & ~rst & (sel == owner_t'(0));
    assign up1.ready = mem.ready & allow & ~rst & (sel == owner_t'(1));

    assign push       = accept & ~sel_we;
    assign pop        = mem.rvalid & ~fifo_empty & ~rst;
    assign up0.rvalid = pop & (head == owner_t'(0));
    assign up1.rvalid = pop & (head == owner_t'(1));
    assign up0.rdata  = mem.rdata;
    assign up1.rdata  = mem.rdata;

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (OWNER_W)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (sel),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
            held    <= owner_t'(0);
            rr_last <= owner_t'(1);
            rsp_err <= 1'b0;
        end else begin
            if (accept) rr_last <= sel;
            if (mem.rvalid && fifo_empty) rsp_err <= 1'b1;
            case (state)
                ARB: begin
                    if (mem.valid && !mem.ready) begin
                        state <= HOLD;
                        held  <= sel;
                    end
                end
                HOLD: begin
                    if (accept) state <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (fifo_count <= CNT_W'(MAX_OUTSTANDING));
    end

endmodule
